dsp_mac_ctrl: RTL and testbench

DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

---
 rtl/dsp_mac_pkg.sv | 26 ++
 rtl/dsp_dly_line.sv | 31 +++
 rtl/dsp_mac_ctrl.sv | 145 ++++++++++++++
 tb/tb_dsp_mac_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate controller.
// Holds the slice OPMODE encodings and the controller FSM state enum.
package dsp_mac_pkg;

    localparam int unsigned OPM_W    = 8;
    localparam int unsigned OPND_W   = 18;
    localparam int unsigned P_W      = 48;

    // Z=0, X=M starts a new sum; Z=P, X=M accumulates; Z=P, X=0 preserves P.
    localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;
    localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
    localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;
    localparam logic [OPM_W-1:0] OPM_RESET = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } mac_state_e;

    function automatic logic [OPM_W-1:0] tap_opmode(input logic first_tap);
        return first_tap ? OPM_FIRST : OPM_ACC;
    endfunction

endpackage

// File: rtl/dsp_dly_line.sv
// Fixed-depth register pipe used to align OPMODE with the slice's multiplier stage.
// Every stage resets to zero so a reset flushes anything in flight.
module dsp_dly_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // NOTE: this is a pipe, not a RAM: each stage carries reset so stale OPMODEs cannot leak out.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Frame controller feeding a DSP48A1 slice: streams TAP_CNT operand pairs, sequences
// OPMODE so the slice accumulates the dot product, then captures and holds P.
module dsp_mac_ctrl
    import dsp_mac_pkg::*;
#(
    parameter int unsigned TAP_CNT = 8,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned OPM_DLY = 2
) (
    input  logic              CLK,
    input  logic              RSTN,

    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [OPND_W-1:0] IN_X,
    input  logic [OPND_W-1:0] IN_COEF,

    output logic [OPND_W-1:0] DSP_A,
    output logic [OPND_W-1:0] DSP_B,
    output logic [OPND_W-1:0] DSP_D,
    output logic [OPM_W-1:0]  DSP_OPMODE,
    input  logic [P_W-1:0]    P_IN,
    input  logic              CARRYOUT_IN,

    output logic [P_W-1:0]    RESULT,
    output logic              RES_CARRY,
    output logic              RES_VALID,
    input  logic              RES_READY
);

    localparam int unsigned TAP_W = $clog2(TAP_CNT);
    localparam int unsigned DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_CNT - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LATENCY - 1);

    mac_state_e        r_state;
    logic [TAP_W-1:0]  r_tap;
    logic [DRN_W-1:0]  r_drain;
    logic              r_in_ready;
    logic [OPND_W-1:0] r_dsp_a;
    logic [OPND_W-1:0] r_dsp_b;
    logic [OPND_W-1:0] r_dsp_d;
    logic [P_W-1:0]    r_result;
    logic              r_res_carry;
    logic              r_res_valid;

    logic              w_accept;
    logic [OPM_W-1:0]  w_opm_next;
    logic [OPM_W-1:0]  w_opm_dly;

    assign w_accept = IN_VALID & r_in_ready;

    // NOTE: a single continuous assign with both arms covered cannot infer a latch.
    assign w_opm_next = w_accept ? tap_opmode(r_tap == '0) : OPM_HOLD;

    // One stage lines OPMODE up with DSP_A/B, the remaining OPM_DLY stages align it with M.
    dsp_dly_line #(
        .WIDTH (OPM_W),
        .DEPTH (OPM_DLY + 1)
    ) u_opm_dly (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .i_din  (w_opm_next),
        .o_dout (w_opm_dly)
    );

    // NOTE: all state here is updated with <= so every branch sees pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= IDLE;
            r_tap       <= '0;
            r_drain     <= '0;
            r_in_ready  <= 1'b0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_dsp_d     <= '0;
            r_result    <= '0;
            r_res_carry <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dsp_a <= IN_X;
                r_dsp_b <= IN_COEF;
                r_dsp_d <= '0;
            end

            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_tap   <= r_tap + TAP_W'(1);
                        r_state <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (w_accept) begin
                        if (r_tap == TAP_LAST) begin
                            r_tap      <= '0;
                            r_drain    <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= DRAIN;
                        end else begin
                            r_tap <= r_tap + TAP_W'(1);
                        end
                    end
                end

                // Wait for the last tap to leave the slice pipeline, then latch P.
                DRAIN: begin
                    if (r_drain == DRN_LAST) begin
                        r_result    <= P_IN;
                        r_res_carry <= CARRYOUT_IN;
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_drain <= r_drain + DRN_W'(1);
                    end
                end

                HOLD: begin
                    if (RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY   = r_in_ready;
    assign DSP_A      = r_dsp_a;
    assign DSP_B      = r_dsp_b;
    assign DSP_D      = r_dsp_d;
    assign DSP_OPMODE = w_opm_dly;
    assign RESULT     = r_result;
    assign RES_CARRY  = r_res_carry;
    assign RES_VALID  = r_res_valid;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Scoreboard bench for dsp_mac_ctrl with a behavioural DSP48A1 accumulate model on P_IN.
// Directed frames push hand-computed results; a monitor pops them as RES_VALID rises.
module tb_dsp_mac_ctrl;

    localparam int unsigned TAP_CNT = 4;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned OPM_DLY = 2;
    localparam longint      PERIOD  = 10;

    typedef logic [17:0] vec4_t [4];
    typedef logic [7:0]  opm8_t [8];

    typedef struct {
        logic [47:0] res;
        logic        carry;
        longint      t_valid;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [17:0] IN_X = '0;
    logic [17:0] IN_COEF = '0;
    logic [17:0] DSP_A, DSP_B, DSP_D;
    logic [7:0]  DSP_OPMODE;
    logic [47:0] P_IN;
    logic        CARRYOUT_IN;
    logic [47:0] RESULT;
    logic        RES_CARRY;
    logic        RES_VALID;
    logic        RES_READY = 1'b1;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [7:0]  opm_log[$];
    logic        log_en = 1'b0;
    logic        prev_valid = 1'b0;
    longint      first_acc_t = 0;
    longint      cons_t = 0;

    always #(PERIOD/2) CLK = ~CLK;

    dsp_mac_ctrl #(
        .TAP_CNT (TAP_CNT),
        .LATENCY (LATENCY),
        .OPM_DLY (OPM_DLY)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_X        (IN_X),
        .IN_COEF     (IN_COEF),
        .DSP_A       (DSP_A),
        .DSP_B       (DSP_B),
        .DSP_D       (DSP_D),
        .DSP_OPMODE  (DSP_OPMODE),
        .P_IN        (P_IN),
        .CARRYOUT_IN (CARRYOUT_IN),
        .RESULT      (RESULT),
        .RES_CARRY   (RES_CARRY),
        .RES_VALID   (RES_VALID),
        .RES_READY   (RES_READY)
    );

    // Slice model: M is aligned with OPMODE OPM_DLY cycles after the operands, and
    // the updated P is on P_IN in the LATENCY-th cycle counting the operand cycle as 1.
    logic [47:0] m_p = '0;
    logic        m_c = 1'b0;
    logic [35:0] m_hist [2] = '{default: '0};

    function automatic logic [48:0] dsp_step(input logic [7:0] opm, input logic [35:0] m,
                                             input logic [47:0] p);
        logic [47:0] x_mux;
        logic [47:0] z_mux;
        x_mux = (opm[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
        z_mux = (opm[3:2] == 2'b10) ? p : 48'd0;
        return {1'b0, x_mux} + {1'b0, z_mux};
    endfunction

    always @(posedge CLK) begin
        {m_c, m_p} <= dsp_step(DSP_OPMODE, m_hist[1], m_p);
        m_hist[1]  <= m_hist[0];
        m_hist[0]  <= 36'(DSP_A) * 36'(DSP_B);
    end

    assign P_IN        = m_p;
    assign CARRYOUT_IN = m_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur by t=%0t", name, $time);
    endtask

    // Monitor: one scoreboard entry per result, compared on the first valid cycle.
    always @(negedge CLK) begin
        if (RSTN && RES_VALID && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h with empty scoreboard", RESULT);
            end else begin
                check("result", 64'(RESULT), 64'(sb[0].res));
                check("res_carry", 64'(RES_CARRY), 64'(sb[0].carry));
                check("res_valid_time", 64'($time), 64'(sb[0].t_valid));
                sb.delete(0);
            end
        end
        prev_valid <= RES_VALID;
    end

    always @(negedge CLK) begin
        if (log_en) opm_log.push_back(DSP_OPMODE);
    end

    task automatic send(input logic [17:0] x, input logic [17:0] c, output longint t_acc);
        int n;
        n = 0;
        IN_VALID = 1'b1;
        IN_X     = x;
        IN_COEF  = c;
        while (IN_READY !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) fail_now("accept_wait");
        @(posedge CLK);
        t_acc = $time;
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic send_frame(input vec4_t xs, input vec4_t cs, input logic [47:0] exp_res,
                              input int gap);
        longint t;
        for (int i = 0; i < 4; i++) begin
            send(xs[i], cs[i], t);
            if (i == 0) first_acc_t = t;
            if (i == 1 && gap > 0) repeat (gap) @(negedge CLK);
        end
        sb.push_back('{res: exp_res, carry: 1'b0, t_valid: t + LATENCY * PERIOD + PERIOD / 2});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(negedge CLK);
    endtask

    task automatic check_opm(input string name, input opm8_t exp_v, input int n);
        int idx;
        idx = -1;
        for (int i = 0; i < opm_log.size(); i++) begin
            if (idx < 0 && opm_log[i] == 8'h01) idx = i;
        end
        if (idx < 0) begin
            fail_now({name, "_first_tap"});
        end else begin
            for (int j = 0; j < n; j++) begin
                if (idx + j < opm_log.size())
                    check(name, 64'(opm_log[idx + j]), 64'(exp_v[j]));
                else
                    fail_now({name, "_short_log"});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dsp_a"},   64'(DSP_A), 64'd0);
        check({tag, "_dsp_b"},   64'(DSP_B), 64'd0);
        check({tag, "_dsp_d"},   64'(DSP_D), 64'd0);
        check({tag, "_opmode"},  64'(DSP_OPMODE), 64'h00);
        check({tag, "_result"},  64'(RESULT), 64'd0);
        check({tag, "_carry"},   64'(RES_CARRY), 64'd0);
        check({tag, "_valid"},   64'(RES_VALID), 64'd0);
        check({tag, "_in_ready"}, 64'(IN_READY), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        longint t;
        int     n;

        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RSTN = 1'b1;
        #1 check("ready_before_edge", 64'(IN_READY), 64'd0);
        @(negedge CLK);
        check("ready_after_edge", 64'(IN_READY), 64'd1);

        // Scenario 1: back-to-back frame.
        opm_log.delete();
        log_en = 1'b1;
        send_frame('{18'd1, 18'd2, 18'd3, 18'd4}, '{18'd5, 18'd6, 18'd7, 18'd8}, 48'd70, 0);
        wait_done();
        log_en = 1'b0;
        check_opm("s1_opmode", '{8'h01, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08, 8'h08, 8'h08}, 5);

        // Scenario 2: three idle cycles between taps 1 and 2.
        opm_log.delete();
        log_en = 1'b1;
        send_frame('{18'd1, 18'd2, 18'd3, 18'd4}, '{18'd5, 18'd6, 18'd7, 18'd8}, 48'd70, 3);
        wait_done();
        log_en = 1'b0;
        check_opm("s2_opmode", '{8'h01, 8'h09, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09, 8'h08}, 8);

        // Scenario 4: full-scale operands, 4*(2^36-2^19+1).
        send_frame('{18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF},
                   '{18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF}, 48'h003F_FFE0_0004, 0);
        wait_done();

        // Scenario 3: consumer stalls for 10 cycles.
        RES_READY = 1'b0;
        send_frame('{18'd10, 18'd20, 18'd30, 18'd40}, '{18'd1, 18'd1, 18'd1, 18'd1}, 48'd100, 0);
        n = 0;
        while (RES_VALID !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) fail_now("s3_valid_wait");
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("s3_hold_result", 64'(RESULT), 64'd100);
            check("s3_hold_valid", 64'(RES_VALID), 64'd1);
            check("s3_hold_ready", 64'(IN_READY), 64'd0);
        end
        RES_READY = 1'b1;
        @(negedge CLK);
        check("s3_release_ready", 64'(IN_READY), 64'd1);
        check("s3_release_valid", 64'(RES_VALID), 64'd0);
        wait_done();

        // Scenario 5: reset after tap 2, then a fresh frame.
        send(18'd9, 18'd9, t);
        send(18'd9, 18'd9, t);
        send(18'd9, 18'd9, t);
        RSTN = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge CLK);
        RSTN = 1'b1;
        #1 check("s5_ready_before_edge", 64'(IN_READY), 64'd0);
        @(negedge CLK);
        check("s5_ready_after_edge", 64'(IN_READY), 64'd1);
        send_frame('{18'd1, 18'd1, 18'd1, 18'd1}, '{18'd2, 18'd2, 18'd2, 18'd2}, 48'd8, 0);
        wait_done();

        // Scenario 6: second frame offered while the first result is held.
        RES_READY = 1'b0;
        send_frame('{18'd1, 18'd2, 18'd3, 18'd4}, '{18'd5, 18'd6, 18'd7, 18'd8}, 48'd70, 0);
        fork
            begin
                send_frame('{18'd2, 18'd3, 18'd4, 18'd5}, '{18'd3, 18'd3, 18'd3, 18'd3}, 48'd42, 0);
            end
            begin
                int m;
                m = 0;
                while (RES_VALID !== 1'b1 && m < 100) begin
                    @(negedge CLK);
                    m++;
                end
                if (m >= 100) fail_now("s6_valid_wait");
                repeat (5) @(negedge CLK);
                check("s6_ready_in_hold", 64'(IN_READY), 64'd0);
                check("s6_valid_in_hold", 64'(RES_VALID), 64'd1);
                RES_READY = 1'b1;
                cons_t = $time + PERIOD / 2;
            end
        join
        wait_done();
        check("s6_tap0_after_consume", 64'(first_acc_t), 64'(cons_t + PERIOD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
